// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e    : fetch controller states
//   PC_INC           : byte distance between consecutive instructions
//   RESET_PC_DEFAULT : default reset program counter
//   word_align()     : clears the two byte-offset bits of an address
package if_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer holding a fetched word while decode is frozen.
//   clk, rst_n         : clock, asynchronous active-low reset
//   load               : capture word_in / pc_in, mark full
//   unload             : entry handed to the output slot, mark empty
//   clear              : discard entry (branch flush), mark empty
//   word_in, pc_in     : instruction word and its address + 4
//   full, word, pc     : buffer state and stored contents
module if_hold_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] word_in,
  input  logic [31:0] pc_in,
  output logic        full,
  output logic [31:0] word,
  output logic [31:0] pc
);

  logic        full_q, full_d;
  logic [31:0] word_q, word_d;
  logic [31:0] pc_q,   pc_d;

  always_comb begin
    full_d = full_q;
    word_d = word_q;
    pc_d   = pc_q;
    if (clear || unload) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      word_d = word_in;
      pc_d   = pc_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      word_q <= '0;
      pc_q   <= '0;
    end else begin
      full_q <= full_d;
      word_q <= word_d;
      pc_q   <= pc_d;
    end
  end

  assign full = full_q;
  assign word = word_q;
  assign pc   = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, requests words from instruction
// memory, buffers one returned word against decode stalls, and redirects
// on taken branches.
//   CLK, RST_N              : clock, asynchronous active-low reset
//   IMEM_REQ, IMEM_ADDR     : fetch request and word-aligned address
//   IMEM_RVALID, IMEM_RDATA : memory response (one outstanding request max)
//   FREEZE                  : decode stall, output word must hold
//   BR_TAKEN, BR_ADDR       : branch redirect and target
//   INSTR, PC_OUT, VALID    : instruction, its address + 4, live flag
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_FETCH | request issued this cycle (branch target if BR_TAKEN)
// ST_WAIT  | request outstanding, response goes to output or buffer
// ST_FULL  | response parked in hold buffer until decode unfreezes
// ST_DROP  | redirected while a request is outstanding; discard it
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        FREEZE,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_ADDR,
  output logic [31:0] INSTR,
  output logic [31:0] PC_OUT,
  output logic        VALID
);

  localparam logic [31:0] RESET_PC_AL = word_align(RESET_PC);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;

  logic         hb_load, hb_unload, hb_clear, hb_full;
  logic [31:0]  hb_word, hb_pc;

  logic [31:0]  br_tgt;
  logic [31:0]  next_pc;
  logic         slot_free;

  assign br_tgt    = word_align(BR_ADDR);
  assign next_pc   = fetch_pc_q + PC_INC;
  assign slot_free = !valid_q || !FREEZE;

  if_hold_buf u_hold_buf (
    .clk     (CLK),
    .rst_n   (RST_N),
    .load    (hb_load),
    .unload  (hb_unload),
    .clear   (hb_clear),
    .word_in (IMEM_RDATA),
    .pc_in   (next_pc),
    .full    (hb_full),
    .word    (hb_word),
    .pc      (hb_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    hb_load    = 1'b0;
    hb_unload  = 1'b0;
    hb_clear   = 1'b0;

    // A consumed word that nothing replaces below leaves the slot empty.
    if (valid_q && !FREEZE) valid_d = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        fetch_pc_d = BR_TAKEN ? br_tgt : pc_q;
        if (BR_TAKEN) begin
          valid_d  = 1'b0;
          hb_clear = 1'b1;
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (BR_TAKEN) begin
          pc_d    = br_tgt;
          valid_d = 1'b0;
          // Response arriving with the branch is stale; nothing left in flight.
          state_d = IMEM_RVALID ? ST_FETCH : ST_DROP;
        end else if (IMEM_RVALID) begin
          pc_d = next_pc;
          if (slot_free) begin
            instr_d  = IMEM_RDATA;
            pc_out_d = next_pc;
            valid_d  = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            hb_load = 1'b1;
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (BR_TAKEN) begin
          hb_clear = 1'b1;
          valid_d  = 1'b0;
          pc_d     = br_tgt;
          state_d  = ST_FETCH;
        end else if (!FREEZE && hb_full) begin
          instr_d   = hb_word;
          pc_out_d  = hb_pc;
          valid_d   = 1'b1;
          hb_unload = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (BR_TAKEN) pc_d = br_tgt;
        if (IMEM_RVALID) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC_AL;
      fetch_pc_q <= RESET_PC_AL;
      instr_q    <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
    end
  end

  // Gated by RST_N so no request is seen while the stage is held in reset.
  assign IMEM_REQ  = RST_N && (state_q == ST_FETCH);
  assign IMEM_ADDR = (state_q == ST_FETCH && BR_TAKEN) ? br_tgt : pc_q;
  assign INSTR     = instr_q;
  assign PC_OUT    = pc_out_q;
  assign VALID     = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        FREEZE = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic [31:0] BR_ADDR = 32'h0;
  logic [31:0] INSTR;
  logic [31:0] PC_OUT;
  logic        VALID;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model controls
  int          mem_lat  = 1;
  bit          mem_rand = 1'b0;
  logic [31:0] mem_xor  = 32'h0;
  int          next_lat = 1;
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  if_fetch dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_RVALID (IMEM_RVALID),
    .IMEM_RDATA  (IMEM_RDATA),
    .FREEZE      (FREEZE),
    .BR_TAKEN    (BR_TAKEN),
    .BR_ADDR     (BR_ADDR),
    .INSTR       (INSTR),
    .PC_OUT      (PC_OUT),
    .VALID       (VALID)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) next_lat <= mem_rand ? int'($urandom_range(1, 3)) : mem_lat;

  // Instruction memory: word at address a is a ^ mem_xor, fixed latency or random 1..3.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IMEM_RVALID <= 1'b0;
      IMEM_RDATA  <= 32'h0;
      mem_pend    <= 1'b0;
      mem_cnt     <= 0;
      mem_addr    <= 32'h0;
    end else begin
      IMEM_RVALID <= 1'b0;
      if (IMEM_REQ) begin
        if (next_lat <= 1) begin
          IMEM_RVALID <= 1'b1;
          IMEM_RDATA  <= IMEM_ADDR ^ mem_xor;
        end else begin
          mem_pend <= 1'b1;
          mem_cnt  <= next_lat - 2;
          mem_addr <= IMEM_ADDR;
        end
      end else if (mem_pend) begin
        if (mem_cnt == 0) begin
          IMEM_RVALID <= 1'b1;
          IMEM_RDATA  <= mem_addr ^ mem_xor;
          mem_pend    <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    logic [31:0] nf, ec, tgt, exp_a;
    int consumed;

    // ---- 1: reset and sequential fetch, 1-cycle memory, data = address
    #1 RST_N = 1'b0;
    repeat (3) step();
    chk1("rst_req", IMEM_REQ, 1'b0);
    chk1("rst_valid", VALID, 1'b0);
    chk("rst_instr", INSTR, 32'h0);
    chk("rst_pcout", PC_OUT, 32'h0);
    RST_N = 1'b1;
    #1;
    chk1("first_req", IMEM_REQ, 1'b1);
    chk("first_addr", IMEM_ADDR, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk1("seq_wait_req", IMEM_REQ, 1'b0);
      chk1("seq_wait_valid", VALID, 1'b0);
      step();
      chk1("seq_valid", VALID, 1'b1);
      chk("seq_instr", INSTR, 32'(4 * k));
      chk("seq_pcout", PC_OUT, 32'(4 * k + 4));
      chk1("seq_req", IMEM_REQ, 1'b1);
      chk("seq_addr", IMEM_ADDR, 32'(4 * k + 4));
    end

    // ---- 2: freeze holds INSTR=8, word 12 parked, no new request
    FREEZE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("frz_instr", INSTR, 32'd8);
      chk("frz_pcout", PC_OUT, 32'd12);
      chk1("frz_valid", VALID, 1'b1);
      chk1("frz_req", IMEM_REQ, 1'b0);
    end
    FREEZE = 1'b0;
    step();
    chk("unfrz_instr", INSTR, 32'd12);
    chk("unfrz_pcout", PC_OUT, 32'd16);
    chk1("unfrz_valid", VALID, 1'b1);
    chk1("unfrz_req", IMEM_REQ, 1'b1);
    chk("unfrz_addr", IMEM_ADDR, 32'd16);

    // ---- 3: branch in WAIT, slow response is dropped
    mem_lat = 4;
    step();
    chk1("br_wait_req", IMEM_REQ, 1'b0);
    BR_TAKEN = 1'b1; BR_ADDR = 32'h100;
    step();
    BR_TAKEN = 1'b0;
    #1;
    chk1("drop_valid", VALID, 1'b0);
    chk1("drop_req", IMEM_REQ, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk1("drop_hold_valid", VALID, 1'b0);
      chk1("drop_hold_req", IMEM_REQ, 1'b0);
    end
    step();
    mem_lat = 1;
    chk1("drop_done_valid", VALID, 1'b0);
    chk1("drop_done_req", IMEM_REQ, 1'b1);
    chk("drop_done_addr", IMEM_ADDR, 32'h100);
    step();
    step();
    chk1("br_valid", VALID, 1'b1);
    chk("br_instr", INSTR, 32'h100);
    chk("br_pcout", PC_OUT, 32'h104);

    // ---- 4: branch in FULL with FREEZE, misaligned target
    FREEZE = 1'b1;
    step();
    step();
    chk1("full_valid", VALID, 1'b1);
    chk("full_instr", INSTR, 32'h100);
    chk1("full_req", IMEM_REQ, 1'b0);
    BR_TAKEN = 1'b1; BR_ADDR = 32'h203;
    step();
    BR_TAKEN = 1'b0; FREEZE = 1'b0;
    #1;
    chk1("fullbr_valid", VALID, 1'b0);
    chk1("fullbr_req", IMEM_REQ, 1'b1);
    chk("fullbr_addr", IMEM_ADDR, 32'h200);
    step();
    step();
    chk("fullbr_instr", INSTR, 32'h200);
    chk("fullbr_pcout", PC_OUT, 32'h204);

    // ---- 5: branch in FETCH, with FREEZE, redirects immediately and flushes
    FREEZE = 1'b1; BR_TAKEN = 1'b1; BR_ADDR = 32'h40;
    #1;
    chk1("fbr_req", IMEM_REQ, 1'b1);
    chk("fbr_addr", IMEM_ADDR, 32'h40);
    step();
    BR_TAKEN = 1'b0; FREEZE = 1'b0;
    #1;
    chk1("fbr_flush", VALID, 1'b0);
    step();
    chk1("fbr_valid", VALID, 1'b1);
    chk("fbr_instr", INSTR, 32'h40);
    chk("fbr_pcout", PC_OUT, 32'h44);

    // ---- 6: async reset in WAIT
    step();
    #2 RST_N = 1'b0;
    #1;
    chk1("arst_valid", VALID, 1'b0);
    chk1("arst_req", IMEM_REQ, 1'b0);
    chk("arst_instr", INSTR, 32'h0);
    mem_xor  = $urandom;
    mem_rand = 1'b1;
    step();
    step();
    RST_N = 1'b1;
    #1;
    chk1("arst_rel_req", IMEM_REQ, 1'b1);
    chk("arst_rel_addr", IMEM_ADDR, 32'h0);

    // ---- random phase: stream model of fetch addresses and consumed words
    nf = 32'h0;
    ec = 32'h0;
    consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      FREEZE   = ($urandom_range(0, 99) < 40);
      BR_TAKEN = ($urandom_range(0, 99) < 8);
      BR_ADDR  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      #1;
      tgt = BR_ADDR & ~32'h3;
      if (IMEM_REQ) begin
        exp_a = BR_TAKEN ? tgt : nf;
        chk("rnd_addr", IMEM_ADDR, exp_a);
        nf = exp_a + 32'd4;
      end else if (BR_TAKEN) begin
        nf = tgt;
      end
      if (BR_TAKEN) begin
        ec = tgt;
      end else if (VALID && !FREEZE) begin
        chk("rnd_instr", INSTR, ec ^ mem_xor);
        chk("rnd_pcout", PC_OUT, ec + 32'd4);
        ec = ec + 32'd4;
        consumed++;
      end
      step();
    end
    chk1("rnd_progress", consumed >= 200, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
